mcu_coef_scheduler: RTL
=======================

# mcu_coef_scheduler

Sits between the entropy decoder and `dq_idct` and keeps the IDCT supplied with coefficients. It double-buffers one MCU of quantized coefficients per bank: YUV_COMPRESSION Y blocks plus one U block and one V block. It raises the per-channel `de` flags once a full MCU is banked. It then replays each 64-coefficient block 64 times in the (u,v) order the IDCT consumes, one replay per output pixel. When the IDCT has finished with a bank, the scheduler releases it back to the decoder.

## Interface
Parameters:
- AMPLITUDE_PRECISION, 16, coefficient width (signed).
- YUV_COMPRESSION, 4, Y blocks per MCU; legal values 1, 2, 4.

Ports:
- i_sysclk, in, 1, single clock.
- i_rstn, in, 1, reset: synchronous, active-low.
- i_coef_valid, in, 1, decoder coefficient valid.
- i_coef_ch, in, 2, channel tag: 0=Y, 1=U, 2=V.
- i_coef, in, AMPLITUDE_PRECISION, coefficient in zigzag-resolved raster order {v,u}.
- o_coef_ready, out, 1, write side accepts a coefficient.
- o_Y_de / o_U_de / o_V_de, out, 1 each, MCU data available per channel.
- i_Y_re / i_U_re / i_V_re, in, 1 each, IDCT read strobes.
- o_Y_B / o_U_B / o_V_B, out, AMPLITUDE_PRECISION each, current coefficient (show-ahead).
- o_mcu_done, out, 1, one-cycle pulse when a bank is released.
- o_err, out, 1, sticky channel-order error.

## Operation
- Write transfer: occurs when `i_coef_valid & o_coef_ready`.
- Write-side expected sequence: YUV_COMPRESSION×64 Y, then 64 U, then 64 V.
  - Counters: coef idx (6b), Y block idx (2b), channel state W_Y → W_U → W_V.
  - After the 64th V coefficient: set `bank_full[wbank]`, toggle wbank, return to W_Y.
- Channel mismatch: a transfer whose `i_coef_ch` ≠ expected channel is accepted and discarded. Counters hold and `o_err` sets. `o_err` clears only on reset.
- `o_coef_ready = ~bank_full[wbank]`.
- Read side, FSM R_IDLE / R_ACTIVE:
  - R_IDLE → R_ACTIVE when `bank_full[rbank]`. All three `de` go high together.
  - Y read pointer: {blk, pass, v, u}, 2+6+6 bits. Each `i_Y_re` advances {v,u}. When {v,u} wraps, pass increments. When pass wraps, blk increments. The coefficient address is {blk, v, u}, so each block is replayed 64 times.
  - U and V pointers are {pass, v, u}. They stop at 4096 reads.
  - `o_U_de` and `o_V_de` drop the cycle after their 4096th read. `o_Y_de` stays high until Y reaches 4096×YUV_COMPRESSION reads.
  - Bank release: when the Y total completes, clear `bank_full[rbank]`, toggle rbank, pulse `o_mcu_done`, and return to R_IDLE. The release happens even if U/V have been read short. The FSM may re-enter R_ACTIVE on the next cycle.
- Strobe handling:
  - `re` while the corresponding `de` is low is ignored (pointer holds).
  - U/V `re` after completion is ignored.
- Simultaneous events:
  - A write completing a bank and a read releasing the other bank in the same cycle both take effect.
  - A write into a bank that the read side is releasing in the same cycle cannot occur, because wbank ≠ rbank whenever both are busy.

## Timing
- Reset (`i_rstn` sampled low) clears everything regardless of any in-flight MCU. Partial banks are discarded.
- Reset values:
  - `o_coef_ready` = 0 while in reset, then 1 on the first cycle after.
  - All `de` = 0, `o_mcu_done` = 0, `o_err` = 0.
  - `o_*_B` = 0.
  - bank_full = 00, wbank = rbank = 0.
- Bank-full to `de` latency: the last V write at edge N sets `bank_full` at N. `de` is high after edge N+1, and `o_*_B` already holds coefficient 0 of block 0.
- Show-ahead read: `o_*_B` is valid whenever `de` = 1. With `re` high at edge K, `o_*_B` shows the next entry after edge K, so back-to-back `re` every cycle is supported. The RAM address mux is `re ? ptr+1 : ptr`, with a registered RAM output.
- `o_mcu_done` is asserted the cycle after the final Y `re` edge.
- Throughput per MCU: write takes (YUV_COMPRESSION+2)×64 cycles minimum; read takes 4096×YUV_COMPRESSION `re` cycles.

## Structure
- Shared package holds:
  - Channel constants C_Y=0, C_U=1, C_V=2.
  - BLK_COEFS=64, BLK_PASSES=64.
  - Write-state encodings W_Y/W_U/W_V and read-state encodings R_IDLE/R_ACTIVE.
- One sub-module, `mcu_coef_bank`: a simple dual-port RAM (1 write port, 1 registered read port) with parameterized depth.
  - Instantiated three times: Y at depth 2×64×YUV_COMPRESSION, U and V at depth 128 each.
  - Address MSB = bank select.
- Top level holds the write counters, read pointers, FSMs, bank_full flags and error logic.

## Test plan
- Single MCU, YUV_COMPRESSION=4: write 384 coefficients with value = index, then assert all `re` continuously.
  - Y read 64 returns 0 (first replay wraps).
  - Y read 4096 starts block 1 with value 64.
  - U returns 256..319 in each pass; U/V `de` drop after 4096 reads.
  - `o_mcu_done` pulses after read 16384.
- Back-pressure: write 2 full MCUs with no reads → `o_coef_ready` = 0 after coefficient 768. After the first release, ready = 1 the next cycle and the third MCU is accepted.
- Channel error: send `ch`=1 at Y coefficient 10 → `o_err` = 1, stays 1, and the write count holds at 10. Correct data resumes normally.
- Gapped `re`: toggle `re` randomly → output sequence identical to the continuous case, and `o_*_B` is stable while `re` = 0.
- YUV_COMPRESSION=1 and 2: `o_mcu_done` after 4096 and 8192 Y reads respectively.
- Reset mid-read at Y read 5000 → all outputs return to reset values. The next MCU written is read from bank 0 starting at coefficient 0.

Source files
------------

// File: rtl/mcu_coef_scheduler_pkg.sv
// mcu_coef_scheduler_pkg: channel tags, block geometry and state encodings shared by the scheduler.
package mcu_coef_scheduler_pkg;
  localparam logic [1:0] C_Y = 2'd0;
  localparam logic [1:0] C_U = 2'd1;
  localparam logic [1:0] C_V = 2'd2;
  localparam int BLK_COEFS = 64;
  localparam int BLK_PASSES = 64;
  typedef enum logic [1:0] {W_Y = C_Y, W_U = C_U, W_V = C_V} wstate_t;
  typedef enum logic {R_IDLE, R_ACTIVE} rstate_t;
endpackage

// File: rtl/mcu_coef_bank.sv
// mcu_coef_bank: simple dual-port RAM, one write port and one registered read port.
module mcu_coef_bank #(
  parameter int W = 16,
  parameter int DEPTH = 128
) (
  input  logic                       i_sysclk,
  input  logic                       i_rstn,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [W-1:0]               wdata,
  input  logic                       re,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [W-1:0]               rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge i_sysclk) begin
    if (we) mem[waddr] <= wdata;
  end
  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/mcu_coef_scheduler.sv
// mcu_coef_scheduler: double-buffers one MCU of coefficients and replays each block 64 times to the IDCT.
module mcu_coef_scheduler
  import mcu_coef_scheduler_pkg::*;
#(
  parameter int AMPLITUDE_PRECISION = 16,
  parameter int YUV_COMPRESSION = 4
) (
  input  logic                           i_sysclk,
  input  logic                           i_rstn,
  input  logic                           i_coef_valid,
  input  logic [1:0]                     i_coef_ch,
  input  logic [AMPLITUDE_PRECISION-1:0] i_coef,
  output logic                           o_coef_ready,
  output logic                           o_Y_de,
  output logic                           o_U_de,
  output logic                           o_V_de,
  input  logic                           i_Y_re,
  input  logic                           i_U_re,
  input  logic                           i_V_re,
  output logic [AMPLITUDE_PRECISION-1:0] o_Y_B,
  output logic [AMPLITUDE_PRECISION-1:0] o_U_B,
  output logic [AMPLITUDE_PRECISION-1:0] o_V_B,
  output logic                           o_mcu_done,
  output logic                           o_err
);
  localparam int YAW = $clog2(2 * BLK_COEFS * YUV_COMPRESSION);
  localparam logic [1:0] YLAST = 2'(YUV_COMPRESSION - 1);
  wstate_t wstate, wstate_n;
  rstate_t rstate, rstate_n;
  logic [1:0] bank_full, bank_full_n;
  logic wbank, rbank;
  logic [5:0] widx;
  logic [1:0] yblk;
  logic [13:0] y_ptr, y_nxt;
  logic [11:0] u_ptr, v_ptr, u_nxt, v_nxt;
  logic u_done, v_done, err;
  logic wr, wacc, blk_end, mcu_end, start, y_re, u_re, v_re, rel;
  assign o_coef_ready = i_rstn & ~bank_full[wbank];
  assign wr = i_coef_valid & o_coef_ready;
  assign wacc = wr & (i_coef_ch == wstate);
  assign blk_end = wacc & (widx == 6'(BLK_COEFS - 1));
  assign mcu_end = blk_end & (wstate == W_V);
  assign o_Y_de = rstate == R_ACTIVE;
  assign o_U_de = o_Y_de & ~u_done;
  assign o_V_de = o_Y_de & ~v_done;
  assign o_err = err;
  assign start = (rstate == R_IDLE) & bank_full[rbank];
  assign y_re = i_Y_re & o_Y_de;
  assign u_re = i_U_re & o_U_de;
  assign v_re = i_V_re & o_V_de;
  // Y pointer is {blk, pass, v, u}; the bank is released after the last pass of the last block
  assign rel = y_re & (y_ptr == {YLAST, 6'(BLK_PASSES - 1), 6'(BLK_COEFS - 1)});
  assign y_nxt = y_ptr + 14'(y_re);
  assign u_nxt = u_ptr + 12'(u_re);
  assign v_nxt = v_ptr + 12'(v_re);
  always_comb begin
    wstate_n = wstate;
    if (blk_end) wstate_n = wstate == W_Y ? (yblk == YLAST ? W_U : W_Y) : wstate == W_U ? W_V : W_Y;
    rstate_n = start ? R_ACTIVE : rel ? R_IDLE : rstate;
    bank_full_n = bank_full;
    if (mcu_end) bank_full_n[wbank] = 1'b1;
    if (rel) bank_full_n[rbank] = 1'b0;
  end
  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) begin
      wstate <= W_Y;
      rstate <= R_IDLE;
    end else begin
      wstate <= wstate_n;
      rstate <= rstate_n;
    end
  end
  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) begin
      bank_full <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      widx <= '0;
      yblk <= '0;
      y_ptr <= '0;
      u_ptr <= '0;
      v_ptr <= '0;
      u_done <= 1'b0;
      v_done <= 1'b0;
      err <= 1'b0;
      o_mcu_done <= 1'b0;
    end else begin
      bank_full <= bank_full_n;
      wbank <= wbank ^ mcu_end;
      rbank <= rbank ^ rel;
      widx <= widx + 6'(wacc);
      if (blk_end && wstate == W_Y) yblk <= yblk == YLAST ? 2'd0 : yblk + 2'd1;
      y_ptr <= rel ? '0 : y_nxt;
      u_ptr <= rel ? '0 : u_nxt;
      v_ptr <= rel ? '0 : v_nxt;
      u_done <= ~rel & (u_done | (u_re & (&u_ptr)));
      v_done <= ~rel & (v_done | (v_re & (&v_ptr)));
      err <= err | (wr & ~wacc);
      o_mcu_done <= rel;
    end
  end
  // read addresses use the show-ahead pointer so back-to-back strobes see the next entry
  mcu_coef_bank #(.W(AMPLITUDE_PRECISION), .DEPTH(2 * BLK_COEFS * YUV_COMPRESSION)) u_bank_y (
    .i_sysclk(i_sysclk), .i_rstn(i_rstn),
    .we(wacc & (wstate == W_Y)),
    .waddr(YAW'((int'(wbank) * YUV_COMPRESSION + int'(yblk)) * BLK_COEFS + int'(widx))),
    .wdata(i_coef),
    .re(start | y_re),
    .raddr(YAW'((int'(rbank) * YUV_COMPRESSION + int'(y_nxt[13:12])) * BLK_COEFS + int'(y_nxt[5:0]))),
    .rdata(o_Y_B)
  );
  mcu_coef_bank #(.W(AMPLITUDE_PRECISION), .DEPTH(2 * BLK_COEFS)) u_bank_u (
    .i_sysclk(i_sysclk), .i_rstn(i_rstn),
    .we(wacc & (wstate == W_U)), .waddr({wbank, widx}), .wdata(i_coef),
    .re(start | u_re), .raddr({rbank, u_nxt[5:0]}), .rdata(o_U_B)
  );
  mcu_coef_bank #(.W(AMPLITUDE_PRECISION), .DEPTH(2 * BLK_COEFS)) u_bank_v (
    .i_sysclk(i_sysclk), .i_rstn(i_rstn),
    .we(wacc & (wstate == W_V)), .waddr({wbank, widx}), .wdata(i_coef),
    .re(start | v_re), .raddr({rbank, v_nxt[5:0]}), .rdata(o_V_B)
  );
endmodule
